// File: rtl/bram1_req_server_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram1_req_server_pkg
// Purpose  : Read-latency, response-depth and width helpers shared by the
//            BRAM request server and its response FIFO.
// Revision : 1.0
// ============================================================================
package bram1_req_server_pkg;

    function automatic int rd_latency(input int pipelined);
        return 1 + pipelined;
    endfunction

    function automatic int rsp_depth(input int pipelined);
        return rd_latency(pipelined) + 2;
    endfunction

    // Never returns 0, so a width derived from it is always legal.
    function automatic int clog2(input int value);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= value) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram1_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bram1_rsp_fifo
// Purpose  : First-word-fall-through response FIFO with occupancy count;
//            the head reads as zero while the FIFO is empty.
// Revision : 1.0
// ============================================================================
module bram1_rsp_fifo
    import bram1_req_server_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 3
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            pop_data_o,
    output logic [clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop_i && (count_q != '0);
    assign w_push = push_i && ((count_q != CW'(DEPTH)) || w_pop);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/bram1_req_server.sv
`default_nettype none
// ============================================================================
// Module   : bram1_req_server
// Purpose  : Valid/ready request front end for a single-port BRAM with
//            in-order, credit-protected read responses.
//            Optional write acks: define BRAM1_REQ_SERVER_WRITE_ACK_EN.
// Revision : 1.0
// ============================================================================
module bram1_req_server
    import bram1_req_server_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_write,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);
    localparam int L   = rd_latency(PIPELINED);
    localparam int D   = rsp_depth(PIPELINED);
    localparam int CW  = clog2(D + 1);
    localparam int CW1 = CW + 1;

    logic [L-1:0]        rd_pipe_q;
    logic [L-1:0]        rd_pipe_d;
    logic                w_track;
    logic [CW-1:0]       w_count;
    logic [CW1-1:0]      w_inflight;
    logic [DATA_WIDTH:0] w_push_data;
    logic [DATA_WIDTH:0] w_pop_data;

    assign bram_en   = req_valid && req_ready;
    assign bram_we   = bram_en && req_write;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;

`ifdef BRAM1_REQ_SERVER_WRITE_ACK_EN
    logic [L-1:0] wr_pipe_q;
    logic [L-1:0] wr_pipe_d;

    assign w_track     = bram_en;
    assign wr_pipe_d   = L'({wr_pipe_q, bram_we});
    // A write leaves the written word on DO, which becomes the ack payload.
    assign w_push_data = {wr_pipe_q[L-1], bram_do};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_pipe_q <= '0;
        end else begin
            wr_pipe_q <= wr_pipe_d;
        end
    end
`else
    assign w_track     = bram_en && !req_write;
    assign w_push_data = {1'b0, bram_do};
`endif

    assign rd_pipe_d = L'({rd_pipe_q, w_track});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q <= rd_pipe_d;
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < L; i++) begin
            w_inflight = w_inflight + CW1'(rd_pipe_q[i]);
        end
    end

    // Credit uses registered state only, so no path from rsp_ready/req_*.
    assign req_ready = (w_inflight + CW1'(w_count)) < CW1'(D);

    bram1_rsp_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (D)
    ) u_rsp_fifo (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .push_i      (rd_pipe_q[L-1]),
        .push_data_i (w_push_data),
        .pop_i       (rsp_valid && rsp_ready),
        .pop_data_o  (w_pop_data),
        .count_o     (w_count)
    );

    assign rsp_valid = (w_count != '0);
    assign rsp_data  = w_pop_data[DATA_WIDTH-1:0];
    assign rsp_write = w_pop_data[DATA_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_bram1_req_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram1_req_server
// Purpose  : Scoreboard bench for a PIPELINED=0 and a PIPELINED=1 server,
//            each in front of a behavioural BRAM1Load-style memory.
// Revision : 1.0
// ============================================================================
module tb_bram1_req_server;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef BRAM1_REQ_SERVER_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic          wr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          CLK;
    logic          RST_N;
    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_write [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_data  [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_data  [2];
    logic          rsp_write [2];
    logic          bram_en   [2];
    logic          bram_we   [2];
    logic [AW-1:0] bram_addr [2];
    logic [DW-1:0] bram_di   [2];
    logic [DW-1:0] bram_do   [2];

    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] do0_q, do1_q, do1_p;
    logic [DW-1:0] sh [2][16];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   rand_rr [2];

    bram1_req_server #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_write(rsp_write[0]),
        .bram_en(bram_en[0]), .bram_we(bram_we[0]), .bram_addr(bram_addr[0]),
        .bram_di(bram_di[0]), .bram_do(bram_do[0])
    );

    bram1_req_server #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_write(rsp_write[1]),
        .bram_en(bram_en[1]), .bram_we(bram_we[1]), .bram_addr(bram_addr[1]),
        .bram_di(bram_di[1]), .bram_do(bram_do[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural BRAMs: write-through DO, DO holds when EN is low,
    // and the pipelined variant re-registers DO every cycle.
    always @(posedge CLK) begin
        if (bram_en[0]) begin
            if (bram_we[0]) begin
                mem0[bram_addr[0]] <= bram_di[0];
                do0_q <= bram_di[0];
            end else begin
                do0_q <= mem0[bram_addr[0]];
            end
        end
        if (bram_en[1]) begin
            if (bram_we[1]) begin
                mem1[bram_addr[1]] <= bram_di[1];
                do1_q <= bram_di[1];
            end else begin
                do1_q <= mem1[bram_addr[1]];
            end
        end
        do1_p <= do1_q;
    end
    assign bram_do[0] = do0_q;
    assign bram_do[1] = do1_p;

    function automatic int lat(input int s);
        return s + 1;
    endfunction

    function automatic int dep(input int s);
        return s + 3;
    endfunction

    function automatic logic [DW-1:0] bp_val(input int i);
        return (i == 3) ? 8'h55 : 8'hA0 + 8'(i);
    endfunction

    function automatic int qsize(input int s);
        return (s == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push_exp(input int s, input exp_t e);
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic check(input string name, input int s, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0h, required %0h", name, s, act, req);
        end
    endtask

    task automatic tick(input int s);
        @(posedge CLK);
        #1;
        if (rand_rr[s]) rsp_ready[s] = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input int s, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_d, input bit timed);
        int   waited;
        bit   ok;
        exp_t e;
        waited = 0;
        ok     = 1'b0;
        req_valid[s] = 1'b1;
        req_write[s] = wr;
        req_addr[s]  = a;
        req_data[s]  = d;
        while (!ok && waited < 200) begin
            @(negedge CLK);
            if (req_ready[s]) begin
                ok    = 1'b1;
                e.cyc = timed ? cyc + 1 + lat(s) : -1;
                if (wr) begin
                    sh[s][a] = d;
                    if (ACK) begin
                        e.wr   = 1'b1;
                        e.data = d;
                        push_exp(s, e);
                    end
                end else begin
                    e.wr   = 1'b0;
                    e.data = exp_d;
                    push_exp(s, e);
                end
            end
            waited++;
            tick(s);
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout dut%0d: addr %0h not accepted, required acceptance within 200 cycles", s, a);
        end
        req_valid[s] = 1'b0;
    endtask

    task automatic drain(input int s);
        int n;
        n = 0;
        while (qsize(s) != 0 && n < 300) begin
            tick(s);
            n++;
        end
        repeat (3) tick(s);
        check("drain_pending", s, qsize(s), 0);
    endtask

    task automatic check_rsp(input int s);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (s == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        end
        vectors++;
        if (!have) begin
            miscompares++;
            $display("FAIL rsp_unexpected dut%0d: got data=%0h write=%0b, required no response",
                     s, rsp_data[s], rsp_write[s]);
        end else if (rsp_data[s] !== e.data || rsp_write[s] !== e.wr || (e.cyc >= 0 && cyc != e.cyc)) begin
            miscompares++;
            $display("FAIL rsp dut%0d: got data=%0h write=%0b cycle=%0d, required data=%0h write=%0b cycle=%0d",
                     s, rsp_data[s], rsp_write[s], cyc, e.data, e.wr, e.cyc);
        end
    endtask

    // Monitor: a response is consumed at the next edge when valid && ready.
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (rsp_valid[0] && rsp_ready[0]) check_rsp(0);
            if (rsp_valid[1] && rsp_ready[1]) check_rsp(1);
        end
    end

    task automatic run_dut(input int s);
        int   acc;
        exp_t e;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        // Back-to-back reads, exact latency per response
        rsp_ready[s] = 1'b1;
        for (int i = 0; i < 8; i++) do_req(s, 1'b0, 4'(i), 8'h00, 8'hA0 + 8'(i), 1'b1);
        drain(s);

        // Write followed immediately by a read of the same address
        do_req(s, 1'b1, 4'd3, 8'h55, 8'h00, 1'b1);
        do_req(s, 1'b0, 4'd3, 8'h00, 8'h55, 1'b1);
        drain(s);

        // Backpressure: only D reads may be accepted
        rsp_ready[s] = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            req_valid[s] = 1'b1;
            req_write[s] = 1'b0;
            req_addr[s]  = 4'(i);
            @(negedge CLK);
            if (req_ready[s]) begin
                acc++;
                e.wr   = 1'b0;
                e.data = bp_val(i);
                e.cyc  = -1;
                push_exp(s, e);
            end
            tick(s);
        end
        req_valid[s] = 1'b0;
        rsp_ready[s] = 1'b1;
        @(negedge CLK);
        check("bp_ready_while_full", s, 32'(req_ready[s]), 0);
        check("bp_accepted", s, acc, dep(s));
        tick(s);
        @(negedge CLK);
        check("ready_after_first_pop", s, 32'(req_ready[s]), 1);
        tick(s);
        for (int i = acc; i < 10; i++) do_req(s, 1'b0, 4'(i), 8'h00, bp_val(i), 1'b0);
        drain(s);

        // Reset with two reads in flight
        do_req(s, 1'b0, 4'd1, 8'h00, 8'hA1, 1'b0);
        do_req(s, 1'b0, 4'd2, 8'h00, 8'hA2, 1'b0);
        #1;
        RST_N = 1'b0;
        if (s == 0) q0.delete();
        else        q1.delete();
        #1;
        check("midrst_rsp_valid", s, 32'(rsp_valid[s]), 0);
        check("midrst_req_ready", s, 32'(req_ready[s]), 1);
        check("midrst_rsp_data",  s, 32'(rsp_data[s]), 0);
        check("midrst_rsp_write", s, 32'(rsp_write[s]), 0);
        check("midrst_bram_en",   s, 32'(bram_en[s]), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) tick(s);
        do_req(s, 1'b0, 4'd5, 8'h00, 8'hA5, 1'b1);
        drain(s);

        // Random mix of reads and writes under random backpressure
        rand_rr[s] = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            do_req(s, wr, a, d, sh[s][a], 1'b0);
            if ($urandom_range(0, 3) == 0) tick(s);
        end
        rand_rr[s]   = 1'b0;
        rsp_ready[s] = 1'b1;
        drain(s);
    endtask

    initial begin
        RST_N = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_write[s] = 1'b0;
            req_addr[s]  = '0;
            req_data[s]  = '0;
            rsp_ready[s] = 1'b0;
            rand_rr[s]   = 1'b0;
            for (int i = 0; i < 16; i++) sh[s][i] = 8'hA0 + 8'(i);
        end
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'hA0 + 8'(i);
            mem1[i] = 8'hA0 + 8'(i);
        end
        do0_q = '0;
        do1_q = '0;
        do1_p = '0;
        #1;
        RST_N = 1'b0;
        #2;
        for (int s = 0; s < 2; s++) begin
            check("reset_req_ready", s, 32'(req_ready[s]), 1);
            check("reset_rsp_valid", s, 32'(rsp_valid[s]), 0);
            check("reset_rsp_write", s, 32'(rsp_write[s]), 0);
            check("reset_rsp_data",  s, 32'(rsp_data[s]), 0);
            check("reset_bram_en",   s, 32'(bram_en[s]), 0);
            check("reset_bram_we",   s, 32'(bram_we[s]), 0);
        end
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        tick(0);
        for (int s = 0; s < 2; s++) run_dut(s);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
